// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the pipeline controller and its hazard scoreboard.
package pipeline_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN,
      ST_HALT
   } state_e;

   localparam logic [3:0] OP_HALT     = 4'b1111;
   localparam int         STALL_CNT_W = 16;

   typedef struct packed {
      logic       valid;
      logic [5:0] rd;
   } slot_t;

   localparam slot_t SLOT_NONE = '{valid: 1'b0, rd: 6'd0};

   function automatic logic slot_hit(input slot_t s, input logic [5:0] r);
      return s.valid && (s.rd == r);
   endfunction

endpackage

// File: rtl/pipeline_controller_hazard_scoreboard.sv
// Two-deep in-flight writer tracker (EX, WB) and RAW hazard compare for the ID stage.
// WB_BYPASS_EN: write-before-read register file, so only the EX slot can cause a hazard.
module hazard_scoreboard
   import pipeline_controller_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       shift_en,
   input  logic       bubble,
   input  logic       regwrt,
   input  logic [5:0] rd,
   input  logic [5:0] rs,
   input  logic [5:0] rt,
   input  logic       reads_rs,
   input  logic       reads_rt,
   output logic       hazard
);

   slot_t ex_slot_q, ex_slot_d;
   slot_t wb_slot_q, wb_slot_d;
   logic  hit_rs, hit_rt;

   always_comb begin
      ex_slot_d = ex_slot_q;
      wb_slot_d = wb_slot_q;
      if (shift_en) begin
         wb_slot_d = ex_slot_q;
         ex_slot_d = bubble ? SLOT_NONE : '{valid: regwrt, rd: rd};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ex_slot_q <= SLOT_NONE;
         wb_slot_q <= SLOT_NONE;
      end else begin
         ex_slot_q <= ex_slot_d;
         wb_slot_q <= wb_slot_d;
      end
   end

`ifdef WB_BYPASS_EN
   assign hit_rs = slot_hit(ex_slot_q, rs);
   assign hit_rt = slot_hit(ex_slot_q, rt);
`else
   assign hit_rs = slot_hit(ex_slot_q, rs) || slot_hit(wb_slot_q, rs);
   assign hit_rt = slot_hit(ex_slot_q, rt) || slot_hit(wb_slot_q, rt);
`endif

   assign hazard = (reads_rs && hit_rs) || (reads_rt && hit_rt);

endmodule

// File: rtl/pipeline_controller.sv
// Run/flush/drain/halt sequencer for a 4-stage pipeline, with stall counting.
// WB_BYPASS_EN (see hazard_scoreboard) drops the WB slot from hazard detection.
module pipeline_controller
   import pipeline_controller_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3:0]             opcode_id,
   input  logic [5:0]             rs_id,
   input  logic [5:0]             rt_id,
   input  logic [5:0]             rd_id,
   input  logic                   reads_rs_id,
   input  logic                   reads_rt_id,
   input  logic                   regWrt_id,
   input  logic                   branch_taken_wb,
   output logic                   pc_we,
   output logic                   ifid_we,
   output logic                   ifid_flush,
   output logic                   idex_bubble,
   output logic                   busy,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   state_e                 state_q, state_d;
   logic                   drain_q, drain_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic                   hazard;
   logic                   shift_en;

   assign shift_en = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

   hazard_scoreboard u_sb (
      .clock    (clock),
      .reset    (reset),
      .shift_en (shift_en),
      .bubble   (idex_bubble),
      .regwrt   (regWrt_id),
      .rd       (rd_id),
      .rs       (rs_id),
      .rt       (rt_id),
      .reads_rs (reads_rs_id),
      .reads_rt (reads_rt_id),
      .hazard   (hazard)
   );

   always_comb begin
      state_d        = state_q;
      drain_d        = drain_q;
      stall_cycles_d = stall_cycles_q;
      pc_we          = 1'b0;
      ifid_we        = 1'b0;
      ifid_flush     = 1'b1;
      idex_bubble    = 1'b1;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (branch_taken_wb) begin
               pc_we   = 1'b1;
               ifid_we = 1'b1;
               state_d = ST_FLUSH;
            end else if (hazard) begin
               ifid_flush = 1'b0;
               if (stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
            end else if (opcode_id == OP_HALT) begin
               ifid_flush = 1'b0;
               drain_d    = 1'b0;
               state_d    = ST_DRAIN;
            end else begin
               pc_we       = 1'b1;
               ifid_we     = 1'b1;
               ifid_flush  = 1'b0;
               idex_bubble = 1'b0;
            end
         end
         // Squashes the wrong-path word the synchronous imem already fetched.
         ST_FLUSH: begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (branch_taken_wb) begin
               pc_we   = 1'b1;
               ifid_we = 1'b1;
               drain_d = 1'b0;
               state_d = ST_FLUSH;
            end else begin
               ifid_flush = 1'b0;
               if (drain_q) begin
                  drain_d = 1'b0;
                  state_d = ST_HALT;
               end else begin
                  drain_d = 1'b1;
               end
            end
         end
         ST_HALT: ifid_flush = 1'b0;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         drain_q        <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_q        <= drain_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign busy         = shift_en;
   assign halted       = (state_q == ST_HALT);
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized + directed bench for pipeline_controller against a behavioural model.
module tb_pipeline_controller;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int EXP_ST = BYP ? 1 : 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_DRAIN = 3, M_HALT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  opcode_id = '0;
   logic [5:0]  rs_id = '0, rt_id = '0, rd_id = '0;
   logic        reads_rs_id = 1'b0, reads_rt_id = 1'b0, regWrt_id = 1'b0, branch_taken_wb = 1'b0;
   logic        pc_we, ifid_we, ifid_flush, idex_bubble, busy, halted;
   logic [15:0] stall_cycles;

   int n_pass = 0, n_total = 0;

   pipeline_controller dut (
      .clock(clock), .reset(reset), .start(start), .opcode_id(opcode_id),
      .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
      .reads_rs_id(reads_rs_id), .reads_rt_id(reads_rt_id), .regWrt_id(regWrt_id),
      .branch_taken_wb(branch_taken_wb),
      .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .busy(busy), .halted(halted), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: mode, writers issued in the last two active cycles (-1 = none), stalls, drain cycles left.
   int m_mode = M_IDLE, m_h0 = -1, m_h1 = -1, m_stall = 0, m_drain = 0;
   int n_mode = M_IDLE, n_h0 = -1, n_h1 = -1, n_stall = 0, n_drain = 0;
   bit seed_req = 1'b0;
   bit e_pc, e_fl, e_bb, hz, act;

   function automatic bit dep(input int src);
      return (m_h0 == src) || (!BYP && m_h1 == src);
   endfunction

   always @(negedge clock) begin
      hz = (reads_rs_id && dep(int'(rs_id))) || (reads_rt_id && dep(int'(rt_id)));
      n_mode = m_mode; n_stall = m_stall; n_drain = m_drain; n_h0 = m_h0; n_h1 = m_h1;
      e_pc = 0; e_fl = 1; e_bb = 1;
      case (m_mode)
         M_IDLE: if (start) n_mode = M_RUN;
         M_RUN:
            if (branch_taken_wb) begin e_pc = 1; n_mode = M_FLUSH; end
            else if (hz) begin e_fl = 0; n_stall = (m_stall == 65535) ? 65535 : m_stall + 1; end
            else if (opcode_id == 4'hF) begin e_fl = 0; n_mode = M_DRAIN; n_drain = 2; end
            else begin e_pc = 1; e_fl = 0; e_bb = 0; end
         M_FLUSH: begin e_pc = 1; n_mode = M_RUN; end
         M_DRAIN:
            if (branch_taken_wb) begin e_pc = 1; n_mode = M_FLUSH; end
            else begin
               e_fl = 0;
               n_drain = m_drain - 1;
               if (n_drain == 0) n_mode = M_HALT;
            end
         default: e_fl = 0;
      endcase
      act = (m_mode == M_RUN) || (m_mode == M_FLUSH) || (m_mode == M_DRAIN);
      if (act) begin
         n_h1 = m_h0;
         n_h0 = (!e_bb && regWrt_id) ? int'(rd_id) : -1;
      end
      chk($sformatf("pc_we m%0d", m_mode), int'(pc_we), int'(e_pc));
      chk($sformatf("ifid_we m%0d", m_mode), int'(ifid_we), int'(e_pc));
      chk($sformatf("ifid_flush m%0d", m_mode), int'(ifid_flush), int'(e_fl));
      chk($sformatf("idex_bubble m%0d", m_mode), int'(idex_bubble), int'(e_bb));
      chk("busy", int'(busy), int'(act));
      chk("halted", int'(halted), int'(m_mode == M_HALT));
      chk("stall_cycles", int'(stall_cycles), m_stall);
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_mode <= M_IDLE; m_h0 <= -1; m_h1 <= -1; m_stall <= 0; m_drain <= 0;
      end else begin
         m_mode <= n_mode; m_h0 <= n_h0; m_h1 <= n_h1; m_drain <= n_drain;
         m_stall <= seed_req ? 65520 : n_stall;
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic set_nop();
      opcode_id = 4'h0; rs_id = 0; rt_id = 0; rd_id = 0;
      reads_rs_id = 0; reads_rt_id = 0; regWrt_id = 0; branch_taken_wb = 0;
   endtask

   task automatic restart();
      reset = 1; set_nop(); start = 0;
      cyc();
      reset = 0; start = 1;
      cyc();
      start = 0;
   endtask

   initial begin
      set_nop();
      repeat (2) cyc();
      #1;
      chk("rst pc_we", int'(pc_we), 0);
      chk("rst ifid_flush", int'(ifid_flush), 1);
      chk("rst idex_bubble", int'(idex_bubble), 1);
      chk("rst busy", int'(busy), 0);
      chk("rst stall", int'(stall_cycles), 0);
      reset = 0;

      // start -> RUN
      start = 1; cyc(); start = 0; #1;
      chk("start busy", int'(busy), 1);
      chk("start pc_we", int'(pc_we), 1);
      chk("start stall", int'(stall_cycles), 0);

      // RAW on r5
      rd_id = 5; regWrt_id = 1; cyc();
      regWrt_id = 0; rd_id = 0; reads_rs_id = 1; rs_id = 5; #1;
      chk("raw first stall pc_we", int'(pc_we), 0);
      repeat (EXP_ST) cyc();
      #1;
      chk("raw stall count", int'(stall_cycles), EXP_ST);
      chk("raw resume pc_we", int'(pc_we), 1);
      cyc();

      // branch during a hazard stall
      set_nop(); rd_id = 7; regWrt_id = 1; cyc();
      set_nop(); reads_rt_id = 1; rt_id = 7; #1;
      chk("br stall pc_we", int'(pc_we), 0);
      branch_taken_wb = 1; #1;
      chk("br pc_we", int'(pc_we), 1);
      chk("br ifid_flush", int'(ifid_flush), 1);
      chk("br idex_bubble", int'(idex_bubble), 1);
      cyc(); #1;
      chk("flush pc_we", int'(pc_we), 1);
      chk("flush ifid_flush", int'(ifid_flush), 1);
      chk("flush stall unchanged", int'(stall_cycles), EXP_ST);
      cyc();
      set_nop();

      // randomized phase
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (reset) reset = 0;
         if ($urandom_range(0, 399) == 0) begin reset = 1; continue; end
         start = (m_mode == M_IDLE || m_mode == M_HALT) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
         opcode_id = ($urandom_range(0, 60) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         rs_id = 6'($urandom_range(0, 3));
         rt_id = 6'($urandom_range(0, 3));
         rd_id = 6'($urandom_range(0, 3));
         reads_rs_id = 1'($urandom_range(0, 1));
         reads_rt_id = 1'($urandom_range(0, 1));
         regWrt_id = 1'($urandom_range(0, 1));
         branch_taken_wb = ($urandom_range(0, 11) == 0);
         if (m_mode == M_HALT && $urandom_range(0, 7) == 0) begin reset = 1; end
      end
      cyc(); reset = 0; set_nop(); start = 0;

      // halt: two drain cycles, then start ignored
      restart();
      opcode_id = 4'hF; #1;
      chk("halt issue pc_we", int'(pc_we), 0);
      cyc(); opcode_id = 4'h0; #1;
      chk("drain1 halted", int'(halted), 0);
      chk("drain1 busy", int'(busy), 1);
      cyc(); #1;
      chk("drain2 halted", int'(halted), 0);
      cyc(); #1;
      chk("halt halted", int'(halted), 1);
      chk("halt busy", int'(busy), 0);
      start = 1; cyc(); cyc(); #1;
      chk("halt sticky", int'(halted), 1);
      chk("halt pc_we", int'(pc_we), 0);
      start = 0;

      // reset during FLUSH
      restart();
      branch_taken_wb = 1; cyc(); branch_taken_wb = 0; #1;
      chk("in flush", int'(ifid_flush), 1);
      reset = 1; #1;
      chk("async rst pc_we", int'(pc_we), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst bubble", int'(idex_bubble), 1);
      cyc(); reset = 0;
      repeat (3) cyc();
      #1;
      chk("post rst pc_we", int'(pc_we), 0);

      // stall counter saturation, counter preloaded near the top
      restart();
      reads_rs_id = 1; rs_id = 5; rd_id = 5; regWrt_id = 1;
      seed_req = 1;
      cyc();
      force dut.stall_cycles_q = 16'hFFF0;
      seed_req = 0;
      #1;
      release dut.stall_cycles_q;
      repeat (60) cyc();
      #1;
      chk("stall saturate", int'(stall_cycles), 65535);

      set_nop();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as below.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  level; begins execution from IDLE.
REQ-005 opcode_id  input  4  opcode of the instruction in IF/ID.
REQ-006 rs_id, rt_id, rd_id  input  6 each  register fields of the instruction in IF/ID.
REQ-007 reads_rs_id, reads_rt_id  input  1 each  instruction in ID sources rs/rt (from control).
REQ-008 regWrt_id  input  1  instruction in ID writes rd.
REQ-009 branch_taken_wb  input  1  branchControl from WB (zero/neg branch or jump resolved).
REQ-010 pc_we  output  1  PC register load enable.
REQ-011 ifid_we  output  1  IF/ID buffer load enable.
REQ-012 ifid_flush  output  1  IF/ID loads a NOP instead of instr.
REQ-013 idex_bubble  output  1  ID/EX loads all-zero control (regWrt, memWrite, branch, jump = 0).
REQ-014 busy  output  1  state is neither IDLE nor HALT.
REQ-015 halted  output  1  state is HALT.
REQ-016 stall_cycles  output  16  count of hazard-stall cycles.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, FLUSH, DRAIN, HALT; stall is a condition in RUN, not a state.
REQ-018 Scoreboard: two slots ex_slot and wb_slot, each {valid, rd[5:0]}; every edge in RUN/FLUSH/DRAIN: wb_slot <= ex_slot; ex_slot <= idex_bubble ? invalid : {regWrt_id, rd_id}.
REQ-019 hazard = (reads_rs_id && rs_id matches a valid slot) || (reads_rt_id && rt_id matches a valid slot); all 64 register numbers compared, no zero-register exclusion.
REQ-020 IDLE: pc_we = ifid_we = 0, ifid_flush = idex_bubble = 1; start=1 -> RUN at next edge.
REQ-021 RUN, no hazard, no branch: pc_we = ifid_we = 1, flush/bubble = 0.
REQ-022 RUN, hazard, no branch: pc_we = ifid_we = 0, idex_bubble = 1; stall_cycles += 1, saturating at 16'hFFFF; retried every cycle with zero added latency once the slot clears.
REQ-023 branch_taken_wb in RUN or DRAIN: highest priority; pc_we = ifid_we = 1, ifid_flush = idex_bubble = 1, ex_slot <= invalid; next state FLUSH; hazard ignored and not counted.
REQ-024 FLUSH: one cycle; pc_we = ifid_we = 1, ifid_flush = 1, idex_bubble = 1 (squashes the synchronous-imem wrong-path fetch); then RUN; branch_taken_wb in FLUSH SHALL be ignored (WB holds a bubble).
REQ-025 opcode_id == OP_HALT in RUN, no hazard, no branch: pc_we = ifid_we = 0, idex_bubble = 1; next state DRAIN.
REQ-026 DRAIN: pc_we = ifid_we = 0, idex_bubble = 1 for exactly 2 cycles via 1-bit counter, then HALT; a branch in DRAIN cancels the halt per REQ-023.
REQ-027 HALT: all enables 0, bubble = 1; start ignored; exit only by reset.

Reset
REQ-028 Reset SHALL force state = IDLE, slots invalid, drain counter 0, stall_cycles 0; outputs take their IDLE values immediately (asynchronously).
REQ-029 Reset mid-stall/flush/drain SHALL abandon the operation with no residual stall or flush after release.

Configuration
REQ-030 With WB_BYPASS_EN defined, the register file is write-before-read, so wb_slot SHALL be excluded from hazard detection (ex_slot only).
REQ-031 Without WB_BYPASS_EN, both slots are compared (max 2 stall cycles per dependency).

Structure
REQ-032 A shared package SHALL hold the state enumeration, OP_HALT (4'b1111), STALL_CNT_W = 16, and the slot struct typedef.
REQ-033 The scoreboard (slots plus hazard compare) SHALL be a sub-module named hazard_scoreboard; FSM and counters stay in pipeline_controller.

Verification
REQ-034 Reset, start=1 one cycle -> busy=1 next edge, pc_we=1, stall_cycles=0.
REQ-035 Issue rd=5 regWrt=1, then an instruction reading rs=5 -> 2 stall cycles, stall_cycles=2 (1 with WB_BYPASS_EN), then pc_we=1.
REQ-036 branch_taken_wb=1 during a hazard stall -> same cycle pc_we=1, ifid_flush=1, idex_bubble=1; next cycle FLUSH; stall_cycles unchanged.
REQ-037 opcode_id=4'b1111 -> 2 DRAIN cycles, then halted=1; start=1 afterwards -> still halted.
REQ-038 Force 65540 hazard cycles -> stall_cycles holds 16'hFFFF.
REQ-039 Assert reset during FLUSH -> IDLE outputs immediately; after release with start=0, pc_we stays 0.
